mips_cpu: RTL and testbench

MIPS_CPU -- requirements
Module: mips_cpu

---
 rtl/mips_cpu.sv | 394 +++++++++++++++++++++++++++++++++++++++
 tb/tb_mips_cpu.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_cpu.sv
// Five-stage in-order MIPS subset pipeline (IF/ID/EX/MEM/WB) with
// forwarding, load-use stall, EX-stage redirects and a HALT instruction.
package mips_pkg;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_NOR,
        ALU_SLT,
        ALU_SLL,
        ALU_SRL,
        ALU_SRA,
        ALU_LINK
    } alu_op_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc4;
        logic [31:0] instr;
    } if_id_t;

    typedef struct packed {
        logic        regwrite;
        logic        memread;
        logic        memwrite;
        logic        beq;
        logic        bne;
        logic        jump;
        logic        jr;
        logic        alusrc;
        logic        varshift;
        alu_op_t     aluop;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  dest;
        logic [4:0]  shamt;
        logic [31:0] imm;
        logic [31:0] pc4;
        logic [25:0] target;
        logic [31:0] a;
        logic [31:0] b;
    } id_ex_t;

    typedef struct packed {
        logic        regwrite;
        logic        memread;
        logic        memwrite;
        logic [4:0]  dest;
        logic [31:0] result;
        logic [31:0] sdata;
    } ex_mem_t;

    typedef struct packed {
        logic        regwrite;
        logic [4:0]  dest;
        logic [31:0] data;
    } mem_wb_t;

endpackage

module mips_imem #(
    parameter int WORDS = 512
) (
    input  logic [31:0] addr,
    output logic [31:0] data
);
    localparam int AW = $clog2(WORDS);

    logic [31:0] memory [0:WORDS-1];
    logic        unused_bits;

    assign unused_bits = ^{addr[31:AW+2], addr[1:0]};
    assign data = memory[addr[AW+1:2]];
endmodule

module mips_dmem #(
    parameter int WORDS = 512
) (
    input  logic        clk,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wd,
    output logic [31:0] rd
);
    localparam int AW = $clog2(WORDS);

    logic [31:0] memory [0:WORDS-1];
    logic        unused_bits;

    // Upper address bits are dropped, so data addresses wrap.
    assign unused_bits = ^{addr[31:AW+2], addr[1:0]};
    assign rd = memory[addr[AW+1:2]];

    always_ff @(posedge clk) begin
        if (we) memory[addr[AW+1:2]] <= wd;
    end
endmodule

module mips_regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [4:0]  wa,
    input  logic [31:0] wd,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic [31:0] rd1,
    output logic [31:0] rd2
);
    logic [31:0] registers [0:31];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) registers[i] <= '0;
        end else if (we && wa != 5'd0) begin
            registers[wa] <= wd;
        end
    end

    // Same-cycle WB data bypasses the array.
    assign rd1 = (ra1 == 5'd0) ? '0 :
                 (we && wa == ra1) ? wd : registers[ra1];
    assign rd2 = (ra2 == 5'd0) ? '0 :
                 (we && wa == ra2) ? wd : registers[ra2];
endmodule

module mips_cpu #(
    parameter int IMEM_WORDS = 512,
    parameter int DMEM_WORDS = 512
) (
    input logic CLK,
    input logic RESET
);
    import mips_pkg::*;

    localparam logic [31:0] PC_MASK = 32'(IMEM_WORDS * 4 - 1);

    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] pc_next;
    logic [31:0] instr_f;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        halted;
    logic        halt_f;
    logic        stall;
    logic        redirect;
    logic        use_rs;
    logic        use_rt;
    logic [31:0] fwd_a;
    logic [31:0] fwd_b;
    logic [31:0] alu_b;
    logic [31:0] alu_y;
    logic [31:0] target;
    logic [31:0] ld_data;
    logic [4:0]  sh;

    if_id_t  ifid;
    id_ex_t  idex;
    id_ex_t  dec;
    ex_mem_t exmem;
    mem_wb_t memwb;

    mips_imem #(.WORDS(IMEM_WORDS)) instruction_ram (
        .addr (pc),
        .data (instr_f)
    );

    mips_regfile register_file (
        .clk (CLK),
        .rst (RESET),
        .we  (memwb.regwrite),
        .wa  (memwb.dest),
        .wd  (memwb.data),
        .ra1 (ifid.instr[25:21]),
        .ra2 (ifid.instr[20:16]),
        .rd1 (rd1),
        .rd2 (rd2)
    );

    mips_dmem #(.WORDS(DMEM_WORDS)) data_ram (
        .clk  (CLK),
        .we   (exmem.memwrite),
        .addr (exmem.result),
        .wd   (exmem.sdata),
        .rd   (ld_data)
    );

    assign pc_plus4 = (pc + 32'd4) & PC_MASK;
    assign halt_f = halted || (instr_f == 32'hFFFF_FFFF);

    always_comb begin
        dec = '0;
        use_rs = 1'b0;
        use_rt = 1'b0;
        dec.rs = ifid.instr[25:21];
        dec.rt = ifid.instr[20:16];
        dec.dest = ifid.instr[20:16];
        dec.shamt = ifid.instr[10:6];
        dec.target = ifid.instr[25:0];
        dec.imm = {{16{ifid.instr[15]}}, ifid.instr[15:0]};
        dec.pc4 = ifid.pc4;
        dec.a = rd1;
        dec.b = rd2;
        if (ifid.valid) begin
            unique case (ifid.instr[31:26])
                6'h00: begin
                    dec.dest = ifid.instr[15:11];
                    dec.regwrite = 1'b1;
                    use_rs = 1'b1;
                    use_rt = 1'b1;
                    unique case (ifid.instr[5:0])
                        6'h00: begin
                            dec.aluop = ALU_SLL;
                            use_rs = 1'b0;
                        end
                        6'h02: begin
                            dec.aluop = ALU_SRL;
                            use_rs = 1'b0;
                        end
                        6'h03: begin
                            dec.aluop = ALU_SRA;
                            use_rs = 1'b0;
                        end
                        6'h04: begin
                            dec.aluop = ALU_SLL;
                            dec.varshift = 1'b1;
                        end
                        6'h06: begin
                            dec.aluop = ALU_SRL;
                            dec.varshift = 1'b1;
                        end
                        6'h07: begin
                            dec.aluop = ALU_SRA;
                            dec.varshift = 1'b1;
                        end
                        6'h08: begin
                            dec.regwrite = 1'b0;
                            dec.jr = 1'b1;
                            use_rt = 1'b0;
                        end
                        6'h20, 6'h21: dec.aluop = ALU_ADD;
                        6'h22, 6'h23: dec.aluop = ALU_SUB;
                        6'h24: dec.aluop = ALU_AND;
                        6'h25: dec.aluop = ALU_OR;
                        6'h26: dec.aluop = ALU_XOR;
                        6'h27: dec.aluop = ALU_NOR;
                        6'h2A: dec.aluop = ALU_SLT;
                        default: begin
                            dec.regwrite = 1'b0;
                            use_rs = 1'b0;
                            use_rt = 1'b0;
                        end
                    endcase
                end
                6'h08, 6'h09: begin
                    dec.regwrite = 1'b1;
                    dec.alusrc = 1'b1;
                    use_rs = 1'b1;
                end
                6'h0C, 6'h0D, 6'h0E: begin
                    dec.regwrite = 1'b1;
                    dec.alusrc = 1'b1;
                    dec.imm = {16'h0, ifid.instr[15:0]};
                    use_rs = 1'b1;
                    unique case (ifid.instr[27:26])
                        2'b00: dec.aluop = ALU_AND;
                        2'b01: dec.aluop = ALU_OR;
                        default: dec.aluop = ALU_XOR;
                    endcase
                end
                6'h23: begin
                    dec.regwrite = 1'b1;
                    dec.memread = 1'b1;
                    dec.alusrc = 1'b1;
                    use_rs = 1'b1;
                end
                6'h2B: begin
                    dec.memwrite = 1'b1;
                    dec.alusrc = 1'b1;
                    use_rs = 1'b1;
                    use_rt = 1'b1;
                end
                6'h04, 6'h05: begin
                    dec.beq = ~ifid.instr[26];
                    dec.bne = ifid.instr[26];
                    use_rs = 1'b1;
                    use_rt = 1'b1;
                end
                6'h02: dec.jump = 1'b1;
                6'h03: begin
                    dec.jump = 1'b1;
                    dec.regwrite = 1'b1;
                    dec.dest = 5'd31;
                    dec.aluop = ALU_LINK;
                end
                default: ;
            endcase
        end
    end

    assign stall = idex.memread && idex.dest != 5'd0 &&
                   ((use_rs && idex.dest == dec.rs) ||
                    (use_rt && idex.dest == dec.rt));

    // EX/MEM is checked last so the younger result wins.
    always_comb begin
        fwd_a = idex.a;
        fwd_b = idex.b;
        if (memwb.regwrite && memwb.dest != 5'd0) begin
            if (memwb.dest == idex.rs) fwd_a = memwb.data;
            if (memwb.dest == idex.rt) fwd_b = memwb.data;
        end
        if (exmem.regwrite && exmem.dest != 5'd0) begin
            if (exmem.dest == idex.rs) fwd_a = exmem.result;
            if (exmem.dest == idex.rt) fwd_b = exmem.result;
        end
    end

    assign alu_b = idex.alusrc ? idex.imm : fwd_b;
    assign sh = idex.varshift ? fwd_a[4:0] : idex.shamt;

    always_comb begin
        unique case (idex.aluop)
            ALU_ADD:  alu_y = fwd_a + alu_b;
            ALU_SUB:  alu_y = fwd_a - alu_b;
            ALU_AND:  alu_y = fwd_a & alu_b;
            ALU_OR:   alu_y = fwd_a | alu_b;
            ALU_XOR:  alu_y = fwd_a ^ alu_b;
            ALU_NOR:  alu_y = ~(fwd_a | alu_b);
            ALU_SLT:  alu_y = {31'h0, $signed(fwd_a) < $signed(alu_b)};
            ALU_SLL:  alu_y = fwd_b << sh;
            ALU_SRL:  alu_y = fwd_b >> sh;
            ALU_SRA:  alu_y = $signed(fwd_b) >>> sh;
            ALU_LINK: alu_y = idex.pc4;
            default:  alu_y = '0;
        endcase
    end

    always_comb begin
        redirect = 1'b0;
        target = (idex.pc4 + {idex.imm[29:0], 2'b00}) & PC_MASK;
        if (idex.beq && fwd_a == fwd_b) redirect = 1'b1;
        if (idex.bne && fwd_a != fwd_b) redirect = 1'b1;
        if (idex.jump) begin
            redirect = 1'b1;
            target = {idex.pc4[31:28], idex.target, 2'b00} & PC_MASK;
        end
        if (idex.jr) begin
            redirect = 1'b1;
            target = fwd_a & PC_MASK;
        end
    end

    always_comb begin
        if (redirect) pc_next = target;
        else if (stall || halt_f) pc_next = pc;
        else pc_next = pc_plus4;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            pc <= '0;
            halted <= 1'b0;
            ifid <= '0;
            idex <= '0;
            exmem <= '0;
            memwb <= '0;
        end else begin
            pc <= pc_next;
            halted <= halt_f && !redirect;
            if (redirect) begin
                ifid <= '0;
            end else if (!stall) begin
                ifid.valid <= !halt_f;
                ifid.pc4 <= pc_plus4;
                ifid.instr <= halt_f ? '0 : instr_f;
            end
            idex <= (redirect || stall) ? '0 : dec;
            exmem.regwrite <= idex.regwrite;
            exmem.memread <= idex.memread;
            exmem.memwrite <= idex.memwrite;
            exmem.dest <= idex.dest;
            exmem.result <= alu_y;
            exmem.sdata <= fwd_b;
            memwb.regwrite <= exmem.regwrite;
            memwb.dest <= exmem.dest;
            memwb.data <= exmem.memread ? ld_data : exmem.result;
        end
    end
endmodule

// File: tb/tb_mips_cpu.sv
// Scoreboard bench for mips_cpu: an instruction-level model predicts
// the writeback stream and final state of directed and random programs.
module tb_mips_cpu;
    localparam int IW = 512;
    localparam int DW = 512;
    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    typedef struct {
        logic [4:0]  d;
        logic [31:0] v;
    } wb_t;

    logic CLK = 1'b0;
    logic RESET = 1'b1;

    int passed = 0;
    int total = 0;
    int cyc = 0;
    int commit_cyc [32];
    bit mon_en = 1'b0;

    wb_t         exp_q [$];
    logic [31:0] prog [$];
    logic [31:0] m_reg [32];
    logic [31:0] m_mem [DW];
    logic [31:0] init_mem [DW];
    logic [31:0] m_halt_pc;

    mips_cpu #(.IMEM_WORDS(IW), .DMEM_WORDS(DW)) dut (
        .CLK   (CLK),
        .RESET (RESET)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= RESET ? 0 : cyc + 1;

    initial begin
        #900000;
        $display("FAIL watchdog: got no finish, required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, required %h", name, act, exp);
    endtask

    always @(negedge CLK) begin : monitor
        wb_t e;
        if (mon_en && !RESET && dut.memwb.regwrite &&
            dut.memwb.dest != 5'd0) begin
            commit_cyc[dut.memwb.dest] = cyc;
            total++;
            if (exp_q.size() == 0) begin
                $display("FAIL wb_extra: got $%0d=%h, required none",
                         dut.memwb.dest, dut.memwb.data);
            end else begin
                e = exp_q.pop_front();
                if (e.d == dut.memwb.dest && e.v == dut.memwb.data)
                    passed++;
                else
                    $display("FAIL wb_seq: got $%0d=%h, required $%0d=%h",
                             dut.memwb.dest, dut.memwb.data, e.d, e.v);
            end
        end
    end

    function automatic logic [31:0] rtype(int fn, int rs, int rt,
                                          int rd, int sh);
        return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
    endfunction

    function automatic logic [31:0] itype(int op, int rs, int rt, int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    function automatic logic [31:0] jtype(int op, int tgt);
        return {6'(op), 26'(tgt)};
    endfunction

    // Sequential instruction-set model: one instruction per step.
    task automatic run_model();
        logic [31:0] pc, pc4, npc, w, a, b, v, simm, zimm, addr;
        logic [4:0] d;
        bit wr;
        pc = 0;
        for (int i = 0; i < 32; i++) m_reg[i] = 0;
        m_mem = init_mem;
        exp_q.delete();
        for (int s = 0; s < 20000; s++) begin
            w = (pc / 4 < prog.size()) ? prog[pc / 4] : 32'h0;
            if (w == HALT) break;
            a = m_reg[w[25:21]];
            b = m_reg[w[20:16]];
            simm = {{16{w[15]}}, w[15:0]};
            zimm = {16'h0, w[15:0]};
            pc4 = (pc + 4) % (IW * 4);
            npc = pc4;
            wr = 0;
            d = w[20:16];
            v = 0;
            addr = ((a + simm) % (DW * 4)) / 4;
            case (w[31:26])
                6'h00: begin
                    wr = 1;
                    d = w[15:11];
                    case (w[5:0])
                        6'h00: v = b << w[10:6];
                        6'h02: v = b >> w[10:6];
                        6'h03: v = $signed(b) >>> w[10:6];
                        6'h04: v = b << a[4:0];
                        6'h06: v = b >> a[4:0];
                        6'h07: v = $signed(b) >>> a[4:0];
                        6'h08: begin wr = 0; npc = a; end
                        6'h20, 6'h21: v = a + b;
                        6'h22, 6'h23: v = a - b;
                        6'h24: v = a & b;
                        6'h25: v = a | b;
                        6'h26: v = a ^ b;
                        6'h27: v = ~(a | b);
                        6'h2A: v = ($signed(a) < $signed(b)) ? 1 : 0;
                        default: wr = 0;
                    endcase
                end
                6'h02: npc = {pc4[31:28], w[25:0], 2'b00};
                6'h03: begin
                    npc = {pc4[31:28], w[25:0], 2'b00};
                    wr = 1;
                    d = 31;
                    v = pc4;
                end
                6'h04: if (a == b) npc = pc4 + (simm << 2);
                6'h05: if (a != b) npc = pc4 + (simm << 2);
                6'h08, 6'h09: begin wr = 1; v = a + simm; end
                6'h0C: begin wr = 1; v = a & zimm; end
                6'h0D: begin wr = 1; v = a | zimm; end
                6'h0E: begin wr = 1; v = a ^ zimm; end
                6'h23: begin wr = 1; v = m_mem[addr]; end
                6'h2B: m_mem[addr] = b;
                default: ;
            endcase
            if (wr && d != 0) begin
                m_reg[d] = v;
                exp_q.push_back('{d: d, v: v});
            end
            pc = npc % (IW * 4);
        end
        m_halt_pc = pc;
    endtask

    task automatic load_prog();
        mon_en = 0;
        @(negedge CLK);
        RESET = 1;
        for (int i = 0; i < IW; i++)
            dut.instruction_ram.memory[i] = (i < prog.size()) ? prog[i] : 0;
        for (int i = 0; i < DW; i++) dut.data_ram.memory[i] = init_mem[i];
        run_model();
        repeat (2) @(negedge CLK);
    endtask

    task automatic go_and_check(string name, int budget);
        int n, bad;
        for (int i = 0; i < 32; i++) commit_cyc[i] = -1;
        mon_en = 1;
        RESET = 0;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge CLK);
            n++;
        end
        if (exp_q.size() != 0) begin
            total++;
            $display("FAIL %s_timeout: got %0d pending writebacks, required 0",
                     name, exp_q.size());
            exp_q.delete();
        end
        repeat (12) @(negedge CLK);
        for (int r = 0; r < 32; r++)
            check($sformatf("%s_r%0d", name, r),
                  dut.register_file.registers[r], m_reg[r]);
        bad = 0;
        for (int i = 0; i < DW; i++)
            if (dut.data_ram.memory[i] !== m_mem[i]) bad++;
        check({name, "_dmem_bad_words"}, 32'(bad), 0);
        check({name, "_halt_pc"}, dut.pc, m_halt_pc);
    endtask

    task automatic gen_prog(int n, bit allow_sw);
        int fns [15] = '{32, 33, 34, 35, 36, 37, 38, 39, 42, 0, 2, 3, 4, 6, 7};
        int ops [5] = '{8, 9, 12, 13, 14};
        int r, rs, rt, rd, off;
        prog.delete();
        for (int k = 0; k < n; k++) begin
            r = $urandom_range(0, 19);
            rs = $urandom_range(0, 7);
            rt = $urandom_range(0, 7);
            rd = $urandom_range(0, 7);
            if (r <= 9)
                prog.push_back(rtype(fns[$urandom_range(0, 14)], rs, rt, rd,
                                     $urandom_range(0, 31)));
            else if (r <= 13 || r == 19)
                prog.push_back(itype(ops[$urandom_range(0, 4)], rs, rt,
                                     $urandom_range(0, 65535)));
            else if (r == 14)
                prog.push_back(itype(35, rs, rt, $urandom_range(0, 65535)));
            else if (r == 15 && allow_sw)
                prog.push_back(itype(43, rs, rt, $urandom_range(0, 65535)));
            else if (r == 16) begin
                off = $urandom_range(0, 3);
                if (k + 1 + off > n) off = n - k - 1;
                prog.push_back(itype($urandom_range(4, 5), rs, rt, off));
            end else if (r == 17)
                prog.push_back(jtype($urandom_range(2, 3),
                                     $urandom_range(k + 1, n)));
            else if (r == 18)
                prog.push_back({6'h1F, 26'($urandom)});
            else
                prog.push_back(32'h0);
        end
        prog.push_back(HALT);
    endtask

    initial begin
        int nz;
        logic [31:0] snap [32];
        logic [31:0] snap_pc;
        for (int i = 0; i < DW; i++) init_mem[i] = 0;
        repeat (3) @(negedge CLK);
        check("reset_pc", dut.pc, 0);
        check("reset_wb_write", {31'h0, dut.memwb.regwrite}, 0);

        prog = {itype(8, 0, 1, 5), itype(8, 0, 2, -3),
                rtype(32, 1, 2, 3, 0), HALT};
        load_prog();
        go_and_check("exfwd", 200);
        check("exfwd_r1", dut.register_file.registers[1], 32'd5);
        check("exfwd_r2", dut.register_file.registers[2], 32'hFFFF_FFFD);
        check("exfwd_r3", dut.register_file.registers[3], 32'd2);

        prog = {itype(8, 0, 1, 'h40), itype(43, 0, 1, 0), itype(35, 0, 4, 0),
                itype(8, 4, 5, 1), HALT};
        load_prog();
        go_and_check("lduse", 200);
        check("lduse_r4", dut.register_file.registers[4], 32'h40);
        check("lduse_r5", dut.register_file.registers[5], 32'h41);
        check("first_wb_cycle", 32'(commit_cyc[1]), 32'd4);
        check("lduse_stall_cycle", 32'(commit_cyc[5]), 32'd8);

        prog = {itype(8, 0, 1, 1), itype(4, 1, 1, 2), itype(8, 0, 2, 7),
                itype(8, 0, 3, 7), itype(8, 0, 4, 9), HALT};
        load_prog();
        go_and_check("branch", 200);
        check("branch_r2", dut.register_file.registers[2], 32'd0);
        check("branch_r3", dut.register_file.registers[3], 32'd0);
        check("branch_r4", dut.register_file.registers[4], 32'd9);

        prog = {jtype(3, 3), itype(8, 6, 7, 1), HALT, itype(8, 0, 6, 3),
                rtype(8, 31, 0, 0, 0)};
        load_prog();
        go_and_check("jump", 200);
        check("jump_r6", dut.register_file.registers[6], 32'd3);
        check("jump_r7", dut.register_file.registers[7], 32'd4);
        check("jump_r31", dut.register_file.registers[31], 32'd4);

        prog = {itype(13, 0, 1, 'h8000), rtype(0, 0, 1, 2, 16),
                rtype(3, 0, 2, 3, 4), rtype(42, 2, 0, 4, 0),
                rtype(39, 0, 0, 5, 0), HALT};
        load_prog();
        go_and_check("logic", 200);
        check("logic_r2", dut.register_file.registers[2], 32'h8000_0000);
        check("logic_r3", dut.register_file.registers[3], 32'hF800_0000);
        check("logic_r4", dut.register_file.registers[4], 32'd1);
        check("logic_r5", dut.register_file.registers[5], 32'hFFFF_FFFF);

        prog = {itype(8, 0, 0, 9), itype(8, 0, 2, 1), itype(8, 0, 1, 7),
                rtype(32, 1, 1, 0, 0), rtype(32, 0, 0, 3, 0), HALT};
        load_prog();
        go_and_check("zero", 200);
        check("zero_r0", dut.register_file.registers[0], 32'd0);
        check("zero_r2", dut.register_file.registers[2], 32'd1);
        check("zero_r3", dut.register_file.registers[3], 32'd0);

        for (int t = 0; t < 8; t++) begin
            gen_prog(40, 1'b1);
            for (int i = 0; i < DW; i++) init_mem[i] = $urandom;
            load_prog();
            go_and_check($sformatf("rand%0d", t), 3000);
        end

        gen_prog(40, 1'b0);
        load_prog();
        mon_en = 0;
        RESET = 0;
        repeat (12) @(negedge CLK);
        RESET = 1;
        repeat (2) @(negedge CLK);
        check("midreset_pc", dut.pc, 0);
        nz = 0;
        for (int r = 0; r < 32; r++)
            if (dut.register_file.registers[r] != 0) nz++;
        check("midreset_nonzero_regs", 32'(nz), 0);
        go_and_check("midreset", 3000);

        for (int r = 0; r < 32; r++) snap[r] = m_reg[r];
        snap_pc = m_halt_pc;
        repeat (100) @(negedge CLK);
        nz = 0;
        for (int r = 0; r < 32; r++)
            if (dut.register_file.registers[r] !== snap[r]) nz++;
        check("halt_hold_changed_regs", 32'(nz), 0);
        check("halt_hold_pc", dut.pc, snap_pc);
        check("halt_hold_pending", 32'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
